// File: rtl/im_loader.sv
// im_loader: writer-side companion to the instruction memory.
//
// Accepts a program image as a byte stream (valid/ready), packs every four
// bytes into a 32-bit instruction word and issues a one-cycle write to the
// instruction memory write port. The CPU is held (cpu_hold) while a load is
// in progress.
//
// Ports:
//   clk, rst              clock (rising edge), async active-high reset
//   load_start            one-cycle start pulse, sampled only when idle
//   load_base, load_len   first word address / word count, sampled with start
//   abort                 cancel an in-progress load
//   byte_in, byte_valid   stream data in
//   byte_ready            loader consumes byte_in this cycle
//   im_we/im_waddr/im_wdata  instruction memory write port
//   busy, cpu_hold        load in progress (identical)
//   done, aborted         one-cycle completion / cancellation pulses
//   checksum              mod-256 sum of bytes accepted in current/last load

module im_loader #(
  parameter int ADDR_W     = 10,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_base,
  input  logic [ADDR_W:0]   load_len,
  input  logic              abort,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_waddr,
  output logic [31:0]       im_wdata,
  output logic              busy,
  output logic              cpu_hold,
  output logic              done,
  output logic              aborted,
  output logic [7:0]        checksum
);

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_WRITE, S_FIN} state_t;

  // Memory depth; a longer request is clamped to this.
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state, state_nx;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   remaining;
  logic [1:0]        bcnt;
  logic [31:0]       wbuf;
  logic [31:0]       wdata_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [7:0]        cks;
  logic              aborted_q;

  logic [ADDR_W:0]   len_clamp;
  logic              active;
  logic              take;
  logic [31:0]       packed_w;

  assign len_clamp = (load_len > DEPTH) ? DEPTH : load_len;
  assign active    = (state == S_RECV) || (state == S_WRITE);
  // abort wins over byte acceptance, so ready is withdrawn while it is high
  assign take      = (state == S_RECV) && byte_valid && !abort;
  // Word buffer contents with the incoming byte shifted in.
  assign packed_w  = BIG_ENDIAN ? {wbuf[23:0], byte_in} : {byte_in, wbuf[31:8]};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next state and outputs
  always_comb begin
    state_nx   = state;
    byte_ready = 1'b0;
    im_we      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (load_start) state_nx = (len_clamp == '0) ? S_FIN : S_RECV;
      end
      S_RECV: begin
        busy       = 1'b1;
        byte_ready = !abort;
        if (abort)                    state_nx = S_IDLE;
        else if (take && bcnt == 2'd3) state_nx = S_WRITE;
      end
      S_WRITE: begin
        busy  = 1'b1;
        im_we = !abort;
        if (abort)                 state_nx = S_IDLE;
        else if (remaining == ONE) state_nx = S_FIN;
        else                       state_nx = S_RECV;
      end
      S_FIN: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign cpu_hold = busy;
  assign aborted  = aborted_q;
  assign checksum = cks;
  assign im_waddr = waddr_q;
  assign im_wdata = wdata_q;

  // Datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr      <= '0;
      remaining <= '0;
      bcnt      <= '0;
      wbuf      <= '0;
      wdata_q   <= '0;
      waddr_q   <= '0;
      cks       <= '0;
      aborted_q <= 1'b0;
    end else begin
      aborted_q <= active && abort;

      if (state == S_IDLE && load_start) begin
        addr      <= load_base;
        remaining <= len_clamp;
        bcnt      <= '0;
        wbuf      <= '0;
        cks       <= '0;
      end

      if (take) begin
        wbuf <= packed_w;
        cks  <= cks + byte_in;
        bcnt <= bcnt + 2'd1;
        // Capture the finished word and its address so the write port
        // holds steady through WRITE and afterwards.
        if (bcnt == 2'd3) begin
          wdata_q <= packed_w;
          waddr_q <= addr;
        end
      end

      if (im_we) begin
        addr      <= addr + 1'b1;   // wraps at the top of memory
        remaining <= remaining - ONE;
        bcnt      <= '0;
      end

      if (active && abort) begin
        bcnt <= '0;
        wbuf <= '0;
      end
    end
  end

endmodule
